// File: rtl/cache_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface : cache_port_arbiter_if
// Purpose   : Requester-side bundle for cache_port_arbiter. It carries the
//             instruction-fetch port (i_*) and the load/store port (d_*).
//             master = CPU side, slave = arbiter side.
// Revision  : 1.0  initial release
// ============================================================================
interface cache_port_arbiter_if #(
   parameter int ADDR_W = 16
);
   // instruction fetch port (read-only)
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic [1:0]        i_size;
   logic              i_ack;
   logic [31:0]       i_rdata;
   logic              i_err;

   // load/store port
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [1:0]        d_size;
   logic [31:0]       d_wdata;
   logic              d_ack;
   logic [31:0]       d_rdata;
   logic              d_err;

   modport master (
      output i_req, i_addr, i_size,
      input  i_ack, i_rdata, i_err,
      output d_req, d_we, d_addr, d_size, d_wdata,
      input  d_ack, d_rdata, d_err
   );

   modport slave (
      input  i_req, i_addr, i_size,
      output i_ack, i_rdata, i_err,
      input  d_req, d_we, d_addr, d_size, d_wdata,
      output d_ack, d_rdata, d_err
   );
endinterface
`default_nettype wire

// File: rtl/cache_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module    : cache_port_arbiter
// Purpose   : Shares one byte-addressed, big-endian cache port between the
//             instruction fetch port and the load/store port. Each request
//             becomes IDLE -> ACCESS -> RESP; the cache bus is active only
//             during ACCESS and the ack pulses during RESP.
// Options   : define CACHE_ALIGN_CHECK_EN to flag misaligned half/word
//             accesses (no memory effect, err=1 on ack).
// Revision  : 1.0  initial release
// ============================================================================
module cache_port_arbiter #(
   parameter int ADDR_W     = 16,
   parameter bit FIXED_PRIO = 1'b0
) (
   input  wire logic             clk,
   input  wire logic             rst,
   cache_port_arbiter_if.slave   bus,
   output logic                  mem_rw,
   output logic [1:0]            mem_size,
   output logic [ADDR_W-1:0]     mem_addr,
   inout  wire  [31:0]           mem_data,
   output logic                  busy
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   localparam logic PORT_I = 1'b0;
   localparam logic PORT_D = 1'b1;

   state_t            state;
   logic              last_grant;
   logic              cmd_port;
   logic              cmd_we;
   logic              cmd_err;
   logic [1:0]        cmd_size;
   logic [31:0]       cmd_wdata;
   logic              mem_rw_q;

   logic              pick_d;
   logic              win_we;
   logic              win_err;
   logic [ADDR_W-1:0] win_addr;
   logic [1:0]        win_size;
   logic [31:0]       win_wdata;
   logic [31:0]       rd_sample;

   // Winner selection: a lone request wins; on a tie either the fetch port
   // wins outright or the port that was not granted last time wins.
   always_comb begin
      pick_d = 1'b0;
      if (bus.i_req && bus.d_req) begin
         pick_d = FIXED_PRIO ? 1'b0 : (last_grant == PORT_I);
      end else begin
         pick_d = bus.d_req;
      end
   end

   // The fetch port never writes.
   assign win_we    = pick_d ? bus.d_we    : 1'b0;
   assign win_addr  = pick_d ? bus.d_addr  : bus.i_addr;
   assign win_size  = pick_d ? bus.d_size  : bus.i_size;
   assign win_wdata = pick_d ? bus.d_wdata : 32'd0;

`ifdef CACHE_ALIGN_CHECK_EN
   assign win_err = ((win_size == 2'd2) && win_addr[0]) ||
                    ((win_size == 2'd3) && (win_addr[1:0] != 2'b00));
`else
   assign win_err = 1'b0;
`endif

   // Writes, null and flagged accesses return zero instead of bus contents.
   assign rd_sample = (cmd_we || cmd_err || (cmd_size == 2'd0)) ? 32'd0 : mem_data;

   // Reset gates the write strobe so an interrupted write never commits.
   assign mem_rw   = mem_rw_q & ~rst;
   assign mem_data = mem_rw ? cmd_wdata : {32{1'bz}};
   assign busy     = (state != ST_IDLE);

   // Sequencer: latch the winner in IDLE, run one cache cycle, pulse the ack.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         last_grant  <= PORT_D;
         cmd_port    <= PORT_I;
         cmd_we      <= 1'b0;
         cmd_err     <= 1'b0;
         cmd_size    <= 2'd0;
         cmd_wdata   <= 32'd0;
         mem_rw_q    <= 1'b0;
         mem_size    <= 2'd0;
         mem_addr    <= '0;
         bus.i_ack   <= 1'b0;
         bus.i_rdata <= 32'd0;
         bus.i_err   <= 1'b0;
         bus.d_ack   <= 1'b0;
         bus.d_rdata <= 32'd0;
         bus.d_err   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.i_req || bus.d_req) begin
                  cmd_port   <= pick_d;
                  last_grant <= pick_d;
                  cmd_we     <= win_we;
                  cmd_err    <= win_err;
                  cmd_size   <= win_size;
                  cmd_wdata  <= win_wdata;
                  mem_rw_q   <= win_we & ~win_err;
                  mem_size   <= win_err ? 2'd0 : win_size;
                  mem_addr   <= win_addr;
                  state      <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               mem_rw_q <= 1'b0;
               mem_size <= 2'd0;
               mem_addr <= '0;
               if (cmd_port == PORT_D) begin
                  bus.d_ack   <= 1'b1;
                  bus.d_rdata <= rd_sample;
                  bus.d_err   <= cmd_err;
               end else begin
                  bus.i_ack   <= 1'b1;
                  bus.i_rdata <= rd_sample;
                  bus.i_err   <= cmd_err;
               end
               state <= ST_RESP;
            end
            ST_RESP: begin
               bus.i_ack   <= 1'b0;
               bus.i_rdata <= 32'd0;
               bus.i_err   <= 1'b0;
               bus.d_ack   <= 1'b0;
               bus.d_rdata <= 32'd0;
               bus.d_err   <= 1'b0;
               state       <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
